// File: rtl/instr_queue.sv
// In-order queue of decoded control words between IR decode and dispatch.
// Optional performance counters are enabled by defining IQ_PERF_CNT_EN.
module instr_queue #(
  parameter int DEPTH  = 8,
  parameter int CW_W   = 128,
  parameter int RVFI_W = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_iq,
  input  logic [CW_W-1:0]         cw_in,
  input  logic [RVFI_W-1:0]       rvfi_in,
  output logic                    iq_ack,
  input  logic                    flush,
  output logic                    deq_valid,
  output logic [CW_W-1:0]         deq_cw,
  output logic [RVFI_W-1:0]       deq_rvfi,
  input  logic                    deq_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             flush_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = CW_W + RVFI_W;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic          deq_fire;

  // Handshakes: upstream holds ld_iq and its data until iq_ack; an entry moves
  // downstream on any cycle with deq_valid & deq_ready. Flush blocks both sides.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (count_q == '0);
    deq_valid = ~empty & ~flush;
    deq_fire  = deq_valid & deq_ready;
    iq_ack    = ld_iq & ~flush & (~full | deq_fire);
    count     = count_q;
    {deq_cw, deq_rvfi} = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (iq_ack) begin
        mem_d[wr_ptr_q[AW-1:0]] = {cw_in, rvfi_in};
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + PW'(iq_ack) - PW'(deq_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; it is only ever read behind a nonzero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef IQ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        flush_prev_q, flush_prev_d;

  always_comb begin
    stall_d      = stall_q;
    fcnt_d       = fcnt_q;
    flush_prev_d = flush;
    if (ld_iq && !iq_ack && !flush && stall_q != '1) stall_d = stall_q + 32'd1;
    if (flush && !flush_prev_q && fcnt_q != '1)       fcnt_d  = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q      <= '0;
      fcnt_q       <= '0;
      flush_prev_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      fcnt_q       <= fcnt_d;
      flush_prev_q <= flush_prev_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = fcnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: cycle-level reference model plus an expected
// queue of PCs; perf counter expectations follow IQ_PERF_CNT_EN.
module tb_instr_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_iq;
  logic [127:0] cw_in;
  logic [159:0] rvfi_in;
  logic         iq_ack;
  logic         flush;
  logic         deq_valid;
  logic [127:0] deq_cw;
  logic [159:0] deq_rvfi;
  logic         deq_ready;
  logic [3:0]   count;
  logic         full;
  logic         empty;
  logic [31:0]  stall_cycles;
  logic [15:0]  flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          stall_m;
  int          fcnt_m;
  logic        fprev_m;
  int          pops;

  instr_queue dut (
    .clk(clk), .rst(rst), .ld_iq(ld_iq), .cw_in(cw_in), .rvfi_in(rvfi_in),
    .iq_ack(iq_ack), .flush(flush), .deq_valid(deq_valid), .deq_cw(deq_cw),
    .deq_rvfi(deq_rvfi), .deq_ready(deq_ready), .count(count), .full(full),
    .empty(empty), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] mk_cw(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_A5A5, 32'h0000_0013, ~pc, pc};
  endfunction

  function automatic logic [159:0] mk_rvfi(input logic [31:0] pc);
    return {pc, 64'hDEAD_BEEF_CAFE_F00D, ~pc, pc + 32'h1000};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    stall_m = 0;
    fcnt_m  = 0;
    fprev_m = 1'b0;
  endtask

  task automatic check_perf();
`ifdef IQ_PERF_CNT_EN
    chk("stall_cycles", 160'(stall_cycles), 160'(stall_m));
    chk("flush_count", 160'(flush_count), 160'(fcnt_m));
`else
    chk("stall_cycles_tied", 160'(stall_cycles), 160'd0);
    chk("flush_count_tied", 160'(flush_count), 160'd0);
`endif
  endtask

  // ---------------- driver: one cycle of stimulus + checks ----------------
  // Entered a couple of time units after a rising edge; leaves at the same
  // offset after the next one.
  task automatic drive_cycle(input logic ld, input logic [31:0] pc, input logic rdy,
                             input logic fl, output logic acked);
    int   cnt_m;
    logic exp_valid, exp_fire, exp_ack;
    ld_iq     = ld;
    cw_in     = mk_cw(pc);
    rvfi_in   = mk_rvfi(pc);
    deq_ready = rdy;
    flush     = fl;
    #1;
    cnt_m     = exp_q.size();
    exp_valid = (cnt_m != 0) && !fl;
    exp_fire  = exp_valid && rdy;
    exp_ack   = ld && !fl && ((cnt_m != 8) || exp_fire);
    chk("iq_ack", 160'(iq_ack), 160'(exp_ack));
    chk("deq_valid", 160'(deq_valid), 160'(exp_valid));
    chk("count", 160'(count), 160'(cnt_m));
    chk("full", 160'(full), 160'(cnt_m == 8));
    chk("empty", 160'(empty), 160'(cnt_m == 0));
    if (exp_valid) begin
      chk("deq_cw", 160'(deq_cw), 160'(mk_cw(exp_q[0])));
      chk("deq_rvfi", deq_rvfi, mk_rvfi(exp_q[0]));
    end
    check_perf();
    @(posedge clk);
    if (ld && !exp_ack && !fl) stall_m++;
    if (fl && !fprev_m) fcnt_m++;
    fprev_m = fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_fire) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (exp_ack) exp_q.push_back(pc);
    end
    acked = exp_ack;
    #2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic ack;
    int   sent;
    int   guard;

    rst = 1'b0; ld_iq = 1'b0; flush = 1'b0; deq_ready = 1'b0;
    cw_in = '0; rvfi_in = '0;
    model_reset();
    pops = 0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", 160'(count), 160'd0);
    chk("rst_empty", 160'(empty), 160'd1);
    chk("rst_deq_valid", 160'(deq_valid), 160'd0);
    chk("rst_iq_ack", 160'(iq_ack), 160'd0);
    rst = 1'b1;
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, ack);

    // Fill with pc 0x60..0x7C, nothing drained
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 32'h60 + 32'(i * 4), 1'b0, 1'b0, ack);
    chk("fill_full", 160'(full), 160'd1);
    // Full, no pop: stall
    drive_cycle(1'b1, 32'h80, 1'b0, 1'b0, ack);
    chk("full_stall_ack", 160'(ack), 160'd0);
    // Full with simultaneous pop: accepted, count stays 8
    drive_cycle(1'b1, 32'h80, 1'b1, 1'b0, ack);
    chk("full_simul_ack", 160'(ack), 160'd1);
    #1;
    chk("full_simul_count", 160'(count), 160'd8);
    // Drain: 0x64..0x7C then 0x80
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, ack);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, ack);
    chk("drain_pops", 160'(pops), 160'd9);

    // Wrap-around: 20 words with 50% ready
    pops  = 0;
    sent  = 0;
    guard = 0;
    while ((sent < 20 || exp_q.size() != 0) && guard < 400) begin
      drive_cycle(sent < 20, 32'h100 + 32'(sent * 4), 1'($urandom_range(0, 1)), 1'b0, ack);
      if (ack) sent++;
      chk("wrap_count_le8", 160'(count <= 4'd8), 160'd1);
      guard++;
    end
    chk("wrap_sent", 160'(sent), 160'd20);
    chk("wrap_pops", 160'(pops), 160'd20);

    // Flush with 5 entries queued and ld_iq held
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, ack);
    drive_cycle(1'b1, 32'h300, 1'b0, 1'b1, ack);
    drive_cycle(1'b1, 32'h300, 1'b1, 1'b1, ack);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, ack);
    chk("post_flush_count", 160'(count), 160'd0);
`ifdef IQ_PERF_CNT_EN
    chk("post_flush_fcnt", 160'(flush_count), 160'd1);
`endif

    // Reset mid-operation with a dequeue in flight
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0, ack);
    ld_iq = 1'b1; cw_in = mk_cw(32'h500); rvfi_in = mk_rvfi(32'h500); deq_ready = 1'b1;
    #1;
    chk("mid_fire_before", 160'(deq_valid & deq_ready), 160'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 160'(count), 160'd0);
    chk("mid_rst_deq_valid", 160'(deq_valid), 160'd0);
    chk("mid_rst_empty", 160'(empty), 160'd1);
    chk("mid_rst_full", 160'(full), 160'd0);
    chk("mid_rst_stall", 160'(stall_cycles), 160'd0);
    @(posedge clk);
    #2;
    ld_iq = 1'b0; deq_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, ack);
    chk("after_rst_empty", 160'(empty), 160'd1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
